xor_lane_sched: RTL

- Shares one registered XOR compute unit between two requester lanes (lane 0, lane 1).
- Each lane presents an operand pair (a, b) over a valid/ready handshake and receives c = a ^ b over a valid/ready response.
- A round-robin arbiter grants one transaction at a time.
- Saturating per-lane grant counters expose usage for debug.

---
 rtl/xor_lane_sched.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/xor_lane_sched.sv
// xor_lane_sched: one registered XOR unit shared by two requester lanes.
// A round-robin arbiter grants one transaction at a time. The result comes
// back on the owner lane's response channel, and saturating per-lane grant
// counters track usage for debug.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   req_valid0/1, req_ready0/1  request handshake per lane
//   a0/b0, a1/b1              operand pairs (WIDTH bits)
//   resp_valid0/1, resp_ready0/1  response handshake per lane
//   c0/c1                     results; zero when the lane does not own DONE
//   busy                      high whenever the unit is not idle
//   grant_cnt0/1              saturating grant counters (CNT_W bits)
module xor_lane_sched #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid0,
    output logic             req_ready0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             resp_valid0,
    input  logic             resp_ready0,
    output logic [WIDTH-1:0] c0,
    input  logic             req_valid1,
    output logic             req_ready1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             resp_valid1,
    input  logic             resp_ready1,
    output logic [WIDTH-1:0] c1,
    output logic             busy,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             prio;
    logic             owner;
    logic             winner;
    logic             any_valid;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    // A lone requester wins regardless of prio; prio only breaks ties.
    always_comb begin
        any_valid = req_valid0 | req_valid1;
        if (req_valid0 && !req_valid1) begin
            winner = 1'b0;
        end else if (req_valid1 && !req_valid0) begin
            winner = 1'b1;
        end else begin
            winner = prio;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready0  = 1'b0;
        req_ready1  = 1'b0;
        resp_valid0 = 1'b0;
        resp_valid1 = 1'b0;
        c0          = '0;
        c1          = '0;
        case (state)
            IDLE: begin
                if (!rst && any_valid) begin
                    req_ready0 = ~winner;
                    req_ready1 = winner;
                    state_nxt  = EXEC;
                end
            end
            EXEC: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (owner) begin
                    resp_valid1 = 1'b1;
                    c1          = result;
                    if (resp_ready1) state_nxt = IDLE;
                end else begin
                    resp_valid0 = 1'b1;
                    c0          = result;
                    if (resp_ready0) state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign accept     = req_ready0 | req_ready1;
    assign busy       = (state != IDLE);
    assign grant_cnt0 = cnt0;
    assign grant_cnt1 = cnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            prio   <= 1'b0;
            owner  <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
            cnt0   <= '0;
            cnt1   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_a  <= winner ? a1 : a0;
                op_b  <= winner ? b1 : b0;
                owner <= winner;
                if (winner) begin
                    if (cnt1 != '1) cnt1 <= cnt1 + 1'b1;
                end else begin
                    if (cnt0 != '1) cnt0 <= cnt0 + 1'b1;
                end
            end
            if (state == EXEC) begin
                result <= op_a ^ op_b;
            end
            // Hand priority to the other lane once the response is taken.
            if (state == DONE && state_nxt == IDLE) begin
                prio <= ~owner;
            end
        end
    end

endmodule
